// File: rtl/eprisc_mem_pkg.sv
`default_nettype none
// ============================================================================
// eprisc_mem_pkg : shared boot-ROM geometry, port ids and arbiter state type
// Revision      : 1.0
// ============================================================================
package eprisc_mem_pkg;

    localparam int ROM_ADDR_W = 12;
    localparam int ROM_DATA_W = 32;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_LOAD  = 1'b1;

    // Encodes which port owns the read currently in flight
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_FETCH  = 2'd1,
        ARB_LOAD   = 2'd2,
        ARB_LOCKED = 2'd3
    } arbState_t;

endpackage
`default_nettype wire

// File: rtl/eprisc_rr_pick2.sv
`default_nettype none
// ============================================================================
// eprisc_rr_pick2 : combinational two-way round-robin picker with lock override
// Revision        : 1.0
// ============================================================================
module eprisc_rr_pick2
    import eprisc_mem_pkg::*;
(
    input  logic iFetchReq,
    input  logic iLoadReq,
    input  logic iLastGnt,
    input  logic iLockHold,
    input  logic iForceFetch,
    output logic oFetchGnt,
    output logic oLoadGnt
);

    always_comb begin
        oFetchGnt = 1'b0;
        oLoadGnt  = 1'b0;
        if (iFetchReq && iLoadReq) begin
            // Starvation bound beats the burst lock, which beats round-robin
            if (iForceFetch) begin
                oFetchGnt = 1'b1;
            end else if (iLockHold) begin
                oLoadGnt = 1'b1;
            end else if (iLastGnt == PORT_LOAD) begin
                oFetchGnt = 1'b1;
            end else begin
                oLoadGnt = 1'b1;
            end
        end else begin
            oFetchGnt = iFetchReq;
            oLoadGnt  = iLoadReq;
        end
    end

endmodule
`default_nettype wire

// File: rtl/eprisc_rom_arbiter.sv
`default_nettype none
// ============================================================================
// eprisc_rom_arbiter : shares the single-ported boot ROM between fetch and load
// Revision           : 1.0
// ============================================================================
module eprisc_rom_arbiter
    import eprisc_mem_pkg::*;
#(
    parameter int pAddrW   = ROM_ADDR_W,
    parameter int pDataW   = ROM_DATA_W,
    parameter int pLockMax = 16
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iFetchReq,
    input  logic [pAddrW-1:0] iFetchAddr,
    output logic              oFetchGnt,
    output logic              oFetchValid,
    output logic [pDataW-1:0] oFetchData,
    input  logic              iLoadReq,
    input  logic [pAddrW-1:0] iLoadAddr,
    input  logic              iLoadLock,
    output logic              oLoadGnt,
    output logic              oLoadValid,
    output logic [pDataW-1:0] oLoadData,
    output logic [pAddrW-1:0] oRomAddr,
    output logic              oRomEnable,
    input  logic [pDataW-1:0] iRomData
);

    localparam int cCntW = $clog2(pLockMax + 1);

    arbState_t         rState;
    arbState_t         wStateNext;
    logic              rLastGnt;
    logic [cCntW-1:0]  rLockCnt;
    logic [pAddrW-1:0] rLastAddr;

    logic wFetchReq;
    logic wLoadReq;
    logic wFetchGnt;
    logic wLoadGnt;
    logic wLockHold;
    logic wForceFetch;
    logic wFetchOwn;
    logic wLoadOwn;

    // No grant may be issued while reset is asserted
    assign wFetchReq   = iFetchReq & ~iRst;
    assign wLoadReq    = iLoadReq  & ~iRst;
    assign wLockHold   = ((rState == ARB_LOAD) || (rState == ARB_LOCKED)) & iLoadLock;
    assign wForceFetch = (rLockCnt == cCntW'(pLockMax));

    eprisc_rr_pick2 uPick (
        .iFetchReq   (wFetchReq),
        .iLoadReq    (wLoadReq),
        .iLastGnt    (rLastGnt),
        .iLockHold   (wLockHold),
        .iForceFetch (wForceFetch),
        .oFetchGnt   (wFetchGnt),
        .oLoadGnt    (wLoadGnt)
    );

    always_ff @(posedge iClk) begin
        if (iRst) begin
            rState    <= ARB_IDLE;
            rLastGnt  <= PORT_LOAD;
            rLockCnt  <= '0;
            rLastAddr <= '0;
        end else begin
            rState <= wStateNext;
            if (wFetchGnt) begin
                rLastGnt  <= PORT_FETCH;
                rLastAddr <= iFetchAddr;
            end else if (wLoadGnt) begin
                rLastGnt  <= PORT_LOAD;
                rLastAddr <= iLoadAddr;
            end
            if (wFetchGnt || !iLoadLock) begin
                rLockCnt <= '0;
            end else if (wLoadGnt && iFetchReq) begin
                rLockCnt <= rLockCnt + cCntW'(1);
            end
        end
    end

    always_comb begin
        wStateNext = ARB_IDLE;
        if (wFetchGnt) begin
            wStateNext = ARB_FETCH;
        end else if (wLoadGnt) begin
            wStateNext = iLoadLock ? ARB_LOCKED : ARB_LOAD;
        end

        // A read still in flight when reset arrives is dropped, not delivered
        wFetchOwn = (rState == ARB_FETCH) & ~iRst;
        wLoadOwn  = ((rState == ARB_LOAD) || (rState == ARB_LOCKED)) & ~iRst;

        oFetchGnt   = wFetchGnt;
        oLoadGnt    = wLoadGnt;
        oFetchValid = wFetchOwn;
        oLoadValid  = wLoadOwn;
        oRomEnable  = wFetchOwn | wLoadOwn;
        oFetchData  = wFetchOwn ? iRomData : '0;
        oLoadData   = wLoadOwn  ? iRomData : '0;

        oRomAddr = rLastAddr;
        if (iRst) begin
            oRomAddr = '0;
        end else if (wFetchGnt) begin
            oRomAddr = iFetchAddr;
        end else if (wLoadGnt) begin
            oRomAddr = iLoadAddr;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eprisc_rom_arbiter.sv
`default_nettype none
// ============================================================================
// tb_eprisc_rom_arbiter : directed bench with a behavioural arbiter/ROM model
// Revision              : 1.0
// ============================================================================
module tb_eprisc_rom_arbiter;

    localparam int AW      = 12;
    localparam int DW      = 32;
    localparam int LOCKMAX = 4;

    logic          iClk = 1'b0;
    logic          iRst = 1'b1;
    logic          iFetchReq = 1'b0;
    logic [AW-1:0] iFetchAddr = '0;
    logic          oFetchGnt, oFetchValid;
    logic [DW-1:0] oFetchData;
    logic          iLoadReq = 1'b0;
    logic [AW-1:0] iLoadAddr = '0;
    logic          iLoadLock = 1'b0;
    logic          oLoadGnt, oLoadValid;
    logic [DW-1:0] oLoadData;
    logic [AW-1:0] oRomAddr;
    logic          oRomEnable;
    logic [DW-1:0] iRomData;

    int vectors    = 0;
    int miscompares = 0;

    always #5 iClk = ~iClk;

    eprisc_rom_arbiter #(.pAddrW(AW), .pDataW(DW), .pLockMax(LOCKMAX)) dut (
        .iClk(iClk), .iRst(iRst),
        .iFetchReq(iFetchReq), .iFetchAddr(iFetchAddr), .oFetchGnt(oFetchGnt),
        .oFetchValid(oFetchValid), .oFetchData(oFetchData),
        .iLoadReq(iLoadReq), .iLoadAddr(iLoadAddr), .iLoadLock(iLoadLock),
        .oLoadGnt(oLoadGnt), .oLoadValid(oLoadValid), .oLoadData(oLoadData),
        .oRomAddr(oRomAddr), .oRomEnable(oRomEnable), .iRomData(iRomData)
    );

    // ROM: registered read, bus floats (modelled as junk) while not enabled
    logic [DW-1:0] rom [0:4095];
    logic [DW-1:0] romQ = '0;
    always @(posedge iClk) romQ <= rom[oRomAddr];
    assign iRomData = oRomEnable ? romQ : 32'hDEADBEEF;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chkStr(input string nm, input string act, input string exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %s, expected %s", nm, act, exp);
        end
    endtask

    // Model: who was last served, who owns the read now, lock streak length
    int            mLast = 1;
    int            mPrev = 0;
    int            mCnt  = 0;
    logic [AW-1:0] mPrevAddr = '0;
    logic [AW-1:0] mHold = '0;
    logic          eF, eL, eFV, eLV, eEn;
    logic [AW-1:0] eAddr;
    logic [DW-1:0] eFD, eLD;

    always @(negedge iClk) begin
        eF = 1'b0; eL = 1'b0; eFV = 1'b0; eLV = 1'b0; eEn = 1'b0;
        eAddr = '0; eFD = '0; eLD = '0;
        if (!iRst) begin
            if (iFetchReq && iLoadReq) begin
                if (mCnt == LOCKMAX)                eF = 1'b1;
                else if (mPrev == 2 && iLoadLock)   eL = 1'b1;
                else if (mLast == 1)                eF = 1'b1;
                else                                eL = 1'b1;
            end else begin
                eF = iFetchReq;
                eL = iLoadReq;
            end
            eAddr = eF ? iFetchAddr : (eL ? iLoadAddr : mHold);
            eFV = (mPrev == 1);
            eLV = (mPrev == 2);
            eEn = (mPrev != 0);
            eFD = eFV ? rom[mPrevAddr] : '0;
            eLD = eLV ? rom[mPrevAddr] : '0;
        end
        chk("fetchGnt",   32'(oFetchGnt),   32'(eF));
        chk("loadGnt",    32'(oLoadGnt),    32'(eL));
        chk("fetchValid", 32'(oFetchValid), 32'(eFV));
        chk("loadValid",  32'(oLoadValid),  32'(eLV));
        chk("romEnable",  32'(oRomEnable),  32'(eEn));
        chk("fetchData",  oFetchData,       eFD);
        chk("loadData",   oLoadData,        eLD);
        chk("romAddr",    32'(oRomAddr),    32'(eAddr));
        if (iRst) begin
            mLast = 1; mPrev = 0; mCnt = 0; mHold = '0;
        end else begin
            mPrev = eF ? 1 : (eL ? 2 : 0);
            if (eF || eL) begin
                mPrevAddr = eAddr;
                mHold     = eAddr;
                mLast     = eF ? 0 : 1;
            end
            if (eF || !iLoadLock)        mCnt = 0;
            else if (eL && iFetchReq)    mCnt = mCnt + 1;
        end
    end

    task automatic drive(input logic f, input logic [AW-1:0] fa,
                         input logic l, input logic [AW-1:0] la, input logic lk);
        iFetchReq = f; iFetchAddr = fa; iLoadReq = l; iLoadAddr = la; iLoadLock = lk;
    endtask

    task automatic toNeg;
        @(negedge iClk); #1;
    endtask

    task automatic toPos;
        @(posedge iClk); #1;
    endtask

    // Requests stay high through reset to prove nothing is granted meanwhile
    task automatic doReset;
        iRst = 1'b1;
        drive(1'b1, 12'h001, 1'b1, 12'h002, 1'b1);
        toNeg;
        chk("rst fetchGnt", 32'(oFetchGnt), 32'd0);
        chk("rst loadGnt",  32'(oLoadGnt),  32'd0);
        toPos;
        toPos;
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        iRst = 1'b0;
    endtask

    function automatic string gntChar;
        return oFetchGnt ? "F" : (oLoadGnt ? "L" : "-");
    endfunction

    typedef struct {
        logic f; logic [AW-1:0] fa; logic l; logic [AW-1:0] la; logic lk;
    } vec_t;

    string seq;

    initial begin
        vec_t tbl [10];
        for (int i = 0; i < 4096; i++) rom[i] = 32'hC0DE0000 | 32'(i);
        rom[0] = 32'h21000110;

        // Single fetch
        doReset;
        drive(1'b1, 12'h000, 1'b0, '0, 1'b0);
        toNeg;
        chk("t1 grant c0",  32'(oFetchGnt),  32'd1);
        chk("t1 enable c0", 32'(oRomEnable), 32'd0);
        toPos;
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        toNeg;
        chk("t1 valid c1",  32'(oFetchValid), 32'd1);
        chk("t1 data c1",   oFetchData,       32'h21000110);
        chk("t1 enable c1", 32'(oRomEnable),  32'd1);
        toPos;
        toNeg;
        chk("t1 enable c2", 32'(oRomEnable), 32'd0);
        toPos;

        // Contention from reset
        doReset;
        drive(1'b1, 12'h010, 1'b1, 12'h0B0, 1'b0);
        seq = "";
        for (int i = 0; i < 4; i++) begin
            toNeg;
            seq = {seq, gntChar()};
            if (i == 1) chk("t2 fetch data c1", oFetchData, 32'hC0DE0010);
            if (i == 2) chk("t2 load data c2",  oLoadData,  32'hC0DE00B0);
            toPos;
        end
        chkStr("t2 grant order", seq, "FLFL");

        // Lock starvation bound
        doReset;
        drive(1'b1, 12'h020, 1'b1, 12'h0C0, 1'b1);
        seq = "";
        for (int i = 0; i < 8; i++) begin
            toNeg;
            seq = {seq, gntChar()};
            toPos;
        end
        chkStr("t3 lock order", seq, "FLLLLFLL");

        // Lock release mid-burst
        drive(1'b1, 12'h020, 1'b1, 12'h0C0, 1'b0);
        seq = "";
        for (int i = 0; i < 3; i++) begin
            toNeg;
            seq = {seq, gntChar()};
            if (i == 1) chk("t4 lockCnt", 32'(dut.rLockCnt), 32'd0);
            toPos;
        end
        chkStr("t4 release order", seq, "FLF");

        // Reset with a read in flight
        drive(1'b0, '0, 1'b1, 12'h0C3, 1'b0);
        toNeg;
        toPos;
        iRst = 1'b1;
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        toNeg;
        chk("t5 loadValid in rst", 32'(oLoadValid), 32'd0);
        chk("t5 enable in rst",    32'(oRomEnable), 32'd0);
        toPos;
        iRst = 1'b0;
        toNeg;
        chk("t5 loadValid after", 32'(oLoadValid), 32'd0);
        chk("t5 romAddr after",   32'(oRomAddr),   32'd0);
        toPos;

        // Idle hold
        drive(1'b0, '0, 1'b1, 12'h0BA, 1'b0);
        toNeg;
        chk("t6 grant", 32'(oLoadGnt), 32'd1);
        toPos;
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        toNeg;
        chk("t6 data c1", oLoadData, 32'hC0DE00BA);
        toPos;
        for (int i = 2; i < 4; i++) begin
            toNeg;
            chk("t6 hold addr", 32'(oRomAddr),   32'h0BA);
            chk("t6 enable",    32'(oRomEnable), 32'd0);
            toPos;
        end

        // Mixed traffic, including a fetch request dropped before grant
        tbl[0] = '{1'b1, 12'h100, 1'b1, 12'h200, 1'b0};
        tbl[1] = '{1'b1, 12'h101, 1'b1, 12'h200, 1'b0};
        tbl[2] = '{1'b0, 12'h000, 1'b1, 12'h201, 1'b1};
        tbl[3] = '{1'b1, 12'h102, 1'b1, 12'h202, 1'b1};
        tbl[4] = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0};
        tbl[5] = '{1'b1, 12'hFFF, 1'b0, 12'h000, 1'b0};
        tbl[6] = '{1'b1, 12'h103, 1'b1, 12'hFFE, 1'b1};
        tbl[7] = '{1'b1, 12'h104, 1'b1, 12'h203, 1'b1};
        tbl[8] = '{1'b0, 12'h000, 1'b1, 12'h204, 1'b0};
        tbl[9] = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0};
        foreach (tbl[i]) begin
            drive(tbl[i].f, tbl[i].fa, tbl[i].l, tbl[i].la, tbl[i].lk);
            toPos;
        end
        toPos;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
